// File: rtl/aicd_sar_ctrl.sv
// Successive-approximation controller: samples, binary-searches the comparator
// through the DAC, publishes the word, then shifts it out MSB first.
module aicd_sar_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic             cmp_in,
  output logic             sample_en,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             sdo,
  output logic             sdo_frame
);

  typedef enum logic [2:0] {IDLE, SAMPLE, CONVERT, DONE, TX} state_t;

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = 16;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] acc, acc_nxt, trial;
  logic             sample_last, bit_last, bit_zero;

  assign trial       = acc | (WIDTH'(1) << idx);
  assign sample_last = (cnt == CW'(SAMPLE_CYCLES - 1));
  assign bit_last    = (cnt == CW'(SETTLE_CYCLES));
  assign bit_zero    = (idx == '0);

  // Only consumed on the decision cycle of CONVERT, so cmp_in never leaks elsewhere.
  always_comb begin
    acc_nxt      = acc;
    acc_nxt[idx] = cmp_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)   state <= IDLE;
    else if (ena) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SAMPLE;
      SAMPLE:  if (sample_last) state_nxt = CONVERT;
      CONVERT: if (bit_last && bit_zero) state_nxt = DONE;
      DONE:    state_nxt = TX;
      TX:      if (bit_zero) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      idx    <= '0;
      acc    <= '0;
      result <= '0;
    end else if (ena) begin
      case (state)
        IDLE: cnt <= '0;
        SAMPLE: begin
          if (sample_last) begin
            cnt <= '0;
            idx <= IW'(WIDTH - 1);
            acc <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        CONVERT: begin
          if (bit_last) begin
            cnt <= '0;
            acc <= acc_nxt;
            if (bit_zero) result <= acc_nxt;
            else          idx    <= idx - IW'(1);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: idx <= IW'(WIDTH - 1);
        TX:   idx <= idx - IW'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    sample_en = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    dac_code  = '0;
    sdo       = 1'b0;
    sdo_frame = 1'b0;
    case (state)
      SAMPLE: begin
        sample_en = 1'b1;
        busy      = 1'b1;
      end
      CONVERT: begin
        busy     = 1'b1;
        dac_code = trial;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        dac_code = acc;
      end
      TX: begin
        busy      = 1'b1;
        sdo_frame = 1'b1;
        sdo       = result[idx];
      end
      default: ;
    endcase
  end

endmodule
